// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU command protocol.
// Accepts one command (A, B, opcode) over a valid/ready port, sends it as three bytes
// (A, B, OP) through an external uart_tx, then waits for one result byte from an external
// uart_rx and returns it with a one-cycle valid pulse, or pulses o_timeout if it never comes.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_a/b/op   command request handshake and payload
//   o_tx_data, o_tx_start, i_tx_done        byte interface to uart_tx
//   i_rx_data, i_rx_done                    byte interface from uart_rx
//   o_result, o_result_valid                last result byte and its update pulse
//   o_timeout                               result wait expired (pulse)
//   o_busy                                  a command is in progress
module uart_alu_host #(
  parameter int unsigned N_DATA         = 8,
  parameter int unsigned NB_OPERATION   = 6,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [N_DATA-1:0]       i_req_a,
  input  logic [N_DATA-1:0]       i_req_b,
  input  logic [NB_OPERATION-1:0] i_req_op,
  output logic [N_DATA-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  input  logic [N_DATA-1:0]       i_rx_data,
  input  logic                    i_rx_done,
  output logic [N_DATA-1:0]       o_result,
  output logic                    o_result_valid,
  output logic                    o_timeout,
  output logic                    o_busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSendA, StWaitA, StSendB, StWaitB, StSendOp, StWaitOp, StWaitRes
  } state_e;

  state_e                  state_q, state_d;
  logic [N_DATA-1:0]       a_q, a_d;
  logic [N_DATA-1:0]       b_q, b_d;
  logic [NB_OPERATION-1:0] op_q, op_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [N_DATA-1:0]       result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    timeout_q, timeout_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StIdle;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          a_d     = i_req_a;
          b_d     = i_req_b;
          op_d    = i_req_op;
          state_d = StSendA;
        end
      end
      StSendA:  state_d = StWaitA;
      StWaitA:  if (i_tx_done) state_d = StSendB;
      StSendB:  state_d = StWaitB;
      StWaitB:  if (i_tx_done) state_d = StSendOp;
      StSendOp: state_d = StWaitOp;
      StWaitOp: begin
        if (i_tx_done) begin
          state_d = StWaitRes;
          cnt_d   = '0;
        end
      end
      StWaitRes: begin
        cnt_d = cnt_q + CntW'(1);
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (i_rx_done) begin
          result_d       = i_rx_data;
          result_valid_d = 1'b1;
          state_d        = StIdle;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded from state so the start pulse drops the instant reset asserts.
  always_comb begin
    o_tx_start = 1'b0;
    o_tx_data  = '0;
    unique case (state_q)
      StSendA:  begin o_tx_start = 1'b1; o_tx_data = a_q; end
      StWaitA:  o_tx_data = a_q;
      StSendB:  begin o_tx_start = 1'b1; o_tx_data = b_q; end
      StWaitB:  o_tx_data = b_q;
      StSendOp: begin o_tx_start = 1'b1; o_tx_data = N_DATA'(op_q); end
      StWaitOp: o_tx_data = N_DATA'(op_q);
      default: ;
    endcase
  end

  assign o_req_ready    = (state_q == StIdle);
  assign o_busy         = (state_q != StIdle);
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_uart_alu_host.sv
module tb_uart_alu_host;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic [7:0] i_req_a = '0;
  logic [7:0] i_req_b = '0;
  logic [5:0] i_req_op = '0;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic [7:0] o_result;
  logic       o_result_valid;
  logic       o_timeout;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  uart_alu_host #(
    .N_DATA(8),
    .NB_OPERATION(6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_a(i_req_a),
    .i_req_b(i_req_b),
    .i_req_op(i_req_op),
    .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start),
    .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done),
    .o_result(o_result),
    .o_result_valid(o_result_valid),
    .o_timeout(o_timeout),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in a SEND cycle: checks the start pulse and byte, then the following WAIT cycle.
  task automatic byte_ok(input string tag, input logic [7:0] exp);
    chk({tag, "_start"}, o_tx_start, 1);
    chk({tag, "_data"}, o_tx_data, exp);
    tick();
    chk({tag, "_start_drop"}, o_tx_start, 0);
    chk({tag, "_data_hold"}, o_tx_data, exp);
  endtask

  task automatic tx_done_pulse();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    i_rx_data = d;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic request(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_req_a     = a;
    i_req_b     = b;
    i_req_op    = op;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_ready", o_req_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_data", o_tx_data, 8'h00);
    chk("rst_result", o_result, 8'h00);
    chk("rst_valid", o_result_valid, 0);
    chk("rst_timeout", o_timeout, 0);
    i_rst_n = 1'b1;
    tick();

    // Basic transaction: 05, 03, 20 -> 08
    request(8'h05, 8'h03, 6'h20);
    chk("basic_busy", o_busy, 1);
    chk("basic_ready", o_req_ready, 0);
    byte_ok("basic_a", 8'h05);
    tick();
    tx_done_pulse();
    byte_ok("basic_b", 8'h03);
    tx_done_pulse();
    byte_ok("basic_op", 8'h20);
    tx_done_pulse();
    chk("basic_waitres_start", o_tx_start, 0);
    chk("basic_waitres_busy", o_busy, 1);
    tick();
    tick();
    rx_pulse(8'h08);
    chk("basic_valid", o_result_valid, 1);
    chk("basic_result", o_result, 8'h08);
    chk("basic_ready_back", o_req_ready, 1);
    tick();
    chk("basic_valid_single", o_result_valid, 0);
    chk("basic_busy_after", o_busy, 0);
    chk("basic_result_hold", o_result, 8'h08);

    // Timeout: no result, pulse exactly 100 cycles after entering WAIT_RES
    request(8'h12, 8'h34, 6'h01);
    byte_ok("to_a", 8'h12);
    tx_done_pulse();
    byte_ok("to_b", 8'h34);
    tx_done_pulse();
    byte_ok("to_op", 8'h01);
    tx_done_pulse();
    repeat (99) tick();
    chk("to_early", o_timeout, 0);
    chk("to_early_busy", o_busy, 1);
    tick();
    chk("to_pulse", o_timeout, 1);
    chk("to_ready", o_req_ready, 1);
    chk("to_result_kept", o_result, 8'h08);
    chk("to_no_valid", o_result_valid, 0);
    tick();
    chk("to_single", o_timeout, 0);

    // Stray rx during WAIT_B is discarded
    request(8'h21, 8'h43, 6'h02);
    byte_ok("stray_a", 8'h21);
    tx_done_pulse();
    byte_ok("stray_b", 8'h43);
    rx_pulse(8'hAA);
    chk("stray_no_valid", o_result_valid, 0);
    chk("stray_result_kept", o_result, 8'h08);
    tick();
    chk("stray_no_valid2", o_result_valid, 0);
    chk("stray_still_waitb", o_tx_data, 8'h43);
    tx_done_pulse();
    byte_ok("stray_op", 8'h02);
    tx_done_pulse();
    tick();
    rx_pulse(8'h11);
    chk("stray_valid", o_result_valid, 1);
    chk("stray_result", o_result, 8'h11);
    tick();
    chk("stray_valid_single", o_result_valid, 0);

    // Back-to-back with i_req_valid held high
    i_req_a     = 8'hFF;
    i_req_b     = 8'h01;
    i_req_op    = 6'h20;
    i_req_valid = 1'b1;
    tick();
    i_req_a  = 8'h10;
    i_req_b  = 8'h04;
    i_req_op = 6'h22;
    byte_ok("b2b1_a", 8'hFF);
    tx_done_pulse();
    byte_ok("b2b1_b", 8'h01);
    tx_done_pulse();
    byte_ok("b2b1_op", 8'h20);
    tx_done_pulse();
    chk("b2b_not_ready", o_req_ready, 0);
    rx_pulse(8'h00);
    chk("b2b1_valid", o_result_valid, 1);
    chk("b2b1_result", o_result, 8'h00);
    chk("b2b1_ready", o_req_ready, 1);
    tick();
    i_req_valid = 1'b0;
    chk("b2b2_valid_drop", o_result_valid, 0);
    byte_ok("b2b2_a", 8'h10);
    tx_done_pulse();
    byte_ok("b2b2_b", 8'h04);
    tx_done_pulse();
    byte_ok("b2b2_op", 8'h22);
    tx_done_pulse();
    rx_pulse(8'h0C);
    chk("b2b2_valid", o_result_valid, 1);
    chk("b2b2_result", o_result, 8'h0C);
    tick();

    // Reset mid-send during WAIT_B
    request(8'h55, 8'h66, 6'h20);
    byte_ok("rs_a", 8'h55);
    tx_done_pulse();
    byte_ok("rs_b", 8'h66);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rs_busy", o_busy, 0);
    chk("rs_ready", o_req_ready, 1);
    chk("rs_start", o_tx_start, 0);
    chk("rs_data", o_tx_data, 8'h00);
    chk("rs_result", o_result, 8'h00);
    tick();
    i_rst_n = 1'b1;
    tick();
    tx_done_pulse();
    chk("rs_late_done_start", o_tx_start, 0);
    chk("rs_late_done_busy", o_busy, 0);
    request(8'h7E, 8'h01, 6'h03);
    byte_ok("rs_new_a", 8'h7E);
    tx_done_pulse();
    byte_ok("rs_new_b", 8'h01);
    tx_done_pulse();
    byte_ok("rs_new_op", 8'h03);
    tx_done_pulse();

    // Result on the expiry cycle wins over the timeout
    repeat (99) tick();
    chk("sim_no_early_timeout", o_timeout, 0);
    rx_pulse(8'h5A);
    chk("sim_valid", o_result_valid, 1);
    chk("sim_timeout", o_timeout, 0);
    chk("sim_result", o_result, 8'h5A);
    tick();
    chk("sim_timeout_after", o_timeout, 0);
    chk("sim_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_alu_host.md
Name: uart_alu_host

Overview:
Host-side initiator for the UART ALU command protocol. It accepts one command (operand A, operand B, opcode) over a valid/ready request port and serializes it as three bytes through a uart_tx instance in the order A, B, OP. It then waits for the single result byte from a uart_rx instance and returns that byte with a one-cycle valid pulse. The block sits opposite uart_alu_interface, on the board or bench that drives the ALU over the serial link, and shares the baudrate_generator tick with its own uart_tx and uart_rx.

Parameters:
N_DATA, 8, width of operands, result and UART byte
NB_OPERATION, 6, opcode width; opcode is sent zero-extended in the low bits of the OP byte
TIMEOUT_CYCLES, 2000000, number of i_clk cycles to wait for the result byte before aborting

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  1  command request valid
o_req_ready  output  1  high only in IDLE; request accepted when i_req_valid & o_req_ready
i_req_a  input  N_DATA  operand A
i_req_b  input  N_DATA  operand B
i_req_op  input  NB_OPERATION  opcode
o_tx_data  output  N_DATA  byte to uart_tx
o_tx_start  output  1  one-cycle start pulse to uart_tx
i_tx_done  input  1  one-cycle pulse from uart_tx at end of stop bit
i_rx_data  input  N_DATA  byte from uart_rx
i_rx_done  input  1  one-cycle pulse from uart_rx, byte valid
o_result  output  N_DATA  last received result, held until the next result
o_result_valid  output  1  one-cycle pulse, o_result updated
o_timeout  output  1  one-cycle pulse, result wait expired
o_busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state is IDLE.
  - All outputs are 0 except o_req_ready=1.
  - Latched A/B/OP registers and timeout counter are 0.
- States: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES.
- IDLE:
  - On handshake at cycle t, latch i_req_a/b/op and go to SEND_A.
  - Request inputs are don't-care after acceptance.
- SEND_x (exactly 1 cycle):
  - o_tx_start=1.
  - o_tx_data = latched byte; the OP byte is {zeros, op}.
  - Next state is WAIT_x.
  - Therefore the first o_tx_start is at t+1.
- WAIT_x:
  - o_tx_start=0 and o_tx_data holds its value.
  - On i_tx_done go to the next SEND state, so the next start pulse is 1 cycle after done.
  - WAIT_OP goes to WAIT_RES on i_tx_done, clearing the timeout counter.
  - i_tx_done seen in SEND or any non-WAIT_x state is ignored.
- WAIT_RES:
  - The counter increments each cycle.
  - On i_rx_done: o_result<=i_rx_data, o_result_valid=1 next cycle, state IDLE.
  - When counter reaches TIMEOUT_CYCLES-1 without i_rx_done: o_timeout=1 next cycle, state IDLE, o_result unchanged.
  - If i_rx_done and expiry occur in the same cycle, the result wins and no timeout is raised.
- i_rx_done outside WAIT_RES (stray or echo bytes while sending) is discarded. It does not update o_result and does not count as the result.
- End-to-end latency: o_result_valid, or o_timeout, and o_req_ready rise in the same cycle. A new request may be accepted in that cycle.
- Only one command is outstanding at a time; there is no queueing.
- Reset mid-operation:
  - Immediate return to IDLE; o_tx_start drops asynchronously.
  - A byte already in flight in uart_tx completes on its own; its i_tx_done after reset is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1). TIMEOUT_CYCLES must be at least 1.

Test Plan:
- Basic transaction:
  - Stimulus: reset, then request A=0x05, B=0x03, op=0x20; bench uart_rx model returns 0x08 after the third byte.
  - Response: tx bytes 0x05, 0x03, 0x20 in order, one o_tx_start per byte, each start 1 cycle after the prior i_tx_done; o_result=0x08 with a single o_result_valid pulse; o_busy low afterwards.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; no rx response after OP.
  - Response: o_timeout pulses exactly 100 cycles after entering WAIT_RES; o_result keeps its previous value; o_req_ready=1.
- Stray rx:
  - Stimulus: inject i_rx_done with 0xAA during WAIT_B, then 0x11 as the real result.
  - Response: o_result=0x11; 0xAA is never presented; exactly one valid pulse.
- Back-to-back:
  - Stimulus: i_req_valid held high with two commands, (0xFF, 0x01, 0x20) then (0x10, 0x04, 0x22).
  - Response: second accepted in the cycle o_result_valid pulses; six tx bytes in order; two results.
- Reset mid-send:
  - Stimulus: assert i_rst_n=0 during WAIT_B, release, then issue a new request A=0x7E.
  - Response: all outputs return to reset values immediately; the late i_tx_done is ignored; the next transaction's first byte is 0x7E.
- Simultaneous events:
  - Stimulus: i_rx_done coincides with the timeout expiry cycle.
  - Response: o_result_valid=1, o_timeout=0.
